// File: rtl/multi_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_shift_pkg
//  Description : Shared state encoding and helpers for the multi-step
//                shift sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_shift_pkg;

    // Sequencer states; width is explicit so the encoding is fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Select index that makes the shifter pass its input through unchanged.
    function automatic int identity_sel_idx(input int max_shift_mag);
        return max_shift_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step_sel.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step_sel
//  Description : Clamps the remaining shift amount to the largest step the
//                shifter can take and produces the step and its one-hot
//                select.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step_sel
    import multi_shift_pkg::*;
#(
    parameter int MAX_SHIFT_MAG = 2,
    parameter int AMT_W         = 6
) (
    input  logic signed [AMT_W-1:0]       i_rem,
    output logic signed [AMT_W-1:0]       o_step,
    output logic [2*MAX_SHIFT_MAG:0]      o_sel
);

    localparam int c_SEL_W = 2 * MAX_SHIFT_MAG + 1;
    localparam int c_ID    = identity_sel_idx(MAX_SHIFT_MAG);

    logic signed [31:0] w_rem_ext;
    logic signed [31:0] w_step_ext;

    // Clamp in 32 bits so the +/-MAX_SHIFT_MAG limits are representable
    // regardless of AMT_W; the clamped result always fits back in AMT_W
    // because it never exceeds |rem|.
    always_comb begin
        w_rem_ext = 32'(i_rem);
        if (w_rem_ext > 32'sd0 + MAX_SHIFT_MAG) begin
            w_step_ext = MAX_SHIFT_MAG;
        end else if (w_rem_ext < -MAX_SHIFT_MAG) begin
            w_step_ext = -MAX_SHIFT_MAG;
        end else begin
            w_step_ext = w_rem_ext;
        end
        o_step = AMT_W'(w_step_ext);
    end

    // Build the one-hot select by comparison so no index can go out of range.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < c_SEL_W; i++) begin
            o_sel[i] = (i == (c_ID + w_step_ext));
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multi_shift_seq
//  Description : Applies an arbitrary signed shift by iterating a bounded
//                combinational shifter, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_shift_seq
    import multi_shift_pkg::*;
#(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int AMT_W         = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:LEN-1]                in_data,
    input  logic signed [AMT_W-1:0]       in_amt,
    output logic [0:LEN-1]                shf_data_o,
    output logic [2*MAX_SHIFT_MAG:0]      shf_sel_o,
    input  logic [0:LEN-1]                shf_data_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [0:LEN-1]                out_data,
    output logic                          busy
);

    localparam int c_SEL_W = 2 * MAX_SHIFT_MAG + 1;
    localparam logic [c_SEL_W-1:0] c_SEL_ID =
        c_SEL_W'(1) << identity_sel_idx(MAX_SHIFT_MAG);

    // Reject illegal parameter sets during elaboration.
    if (MAX_SHIFT_MAG < 1 || MAX_SHIFT_MAG > LEN - 1) begin : g_bad_mag
        $error("multi_shift_seq: MAX_SHIFT_MAG must be in 1..LEN-1");
    end
    if (AMT_W < 2) begin : g_bad_amt_w
        $error("multi_shift_seq: AMT_W must be at least 2");
    end

    state_e                    r_state_q, w_state_d;
    logic [0:LEN-1]            r_acc_q,   w_acc_d;
    logic signed [AMT_W-1:0]   r_rem_q,   w_rem_d;

    logic signed [AMT_W-1:0]   w_step;
    logic [c_SEL_W-1:0]        w_step_sel;
    logic signed [AMT_W:0]     w_amt_ext;
    logic [AMT_W:0]            w_amt_abs;
    logic                      w_oversize;
    logic                      w_run;

    shift_step_sel #(
        .MAX_SHIFT_MAG (MAX_SHIFT_MAG),
        .AMT_W         (AMT_W)
    ) u_step_sel (
        .i_rem  (r_rem_q),
        .o_step (w_step),
        .o_sel  (w_step_sel)
    );

    // Magnitude taken one bit wider so the most-negative amount is exact.
    always_comb begin
        w_amt_ext  = {in_amt[AMT_W-1], in_amt};
        w_amt_abs  = w_amt_ext[AMT_W] ? $unsigned(-w_amt_ext) : $unsigned(w_amt_ext);
        w_oversize = (32'(w_amt_abs) >= 32'(LEN));
    end

    // Select only leaves identity while actually iterating; reset forces it.
    always_comb begin
        w_run      = (r_state_q == RUN) && !rst;
        shf_sel_o  = w_run ? w_step_sel : c_SEL_ID;
        shf_data_o = r_acc_q;
        in_ready   = (r_state_q == IDLE) && !rst;
        out_valid  = (r_state_q == DONE);
        out_data   = r_acc_q;
        busy       = (r_state_q != IDLE);
    end

    // Next-state, accumulator and remaining-amount logic.
    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_rem_d   = r_rem_q;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_acc_d = in_data;
                    w_rem_d = in_amt;
                    if (in_amt == '0) begin
                        w_state_d = DONE;
                    end else if (w_oversize) begin
                        w_acc_d   = '0;
                        w_state_d = DONE;
                    end else begin
                        w_state_d = RUN;
                    end
                end
            end
            RUN: begin
                w_acc_d = shf_data_i;
                w_rem_d = r_rem_q - w_step;
                if (w_rem_d == '0) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_rem_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_rem_q   <= w_rem_d;
        end
    end

endmodule
`default_nettype wire
